// File: rtl/inst_seq_pkg.sv
// rtl/inst_seq_pkg.sv - shared constants, opcodes and state encoding for inst_sequencer
//
// Purpose: register-bank address map, opcode values, completion status codes,
//          the sequencer state encoding and small decode helpers.
// Ports:   none (package).

package inst_seq_pkg;

  localparam logic [15:0] DATA_BASE = 16'h0100;
  localparam logic [15:0] INST_BASE = 16'h0110;
  localparam logic [15:0] INTR_ADDR = 16'h0122;

  // Data registers R0..R9 are the only legal operand/destination indices.
  localparam logic [3:0] LAST_DATA_REG = 4'd9;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_SHL1 = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ST_OK  = 2'd1;
  localparam logic [1:0] ST_ERR = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ_A,
    S_READ_B,
    S_WRITE,
    S_NEXT,
    S_FINISH,
    S_DONE
  } state_t;

  // Opcodes that read two operands and write a data register.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHL1);
  endfunction

  function automatic logic reg_ok(input logic [3:0] idx);
    return idx <= LAST_DATA_REG;
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// rtl/inst_sequencer_if.sv - register bank read-select / write-decoder bus
//
// Purpose: bundles the sequencer's connection to the 64-bit register bank.
// Signals:
//   rd_addr  16      read-select address into the bank read mux
//   rd_data  DATA_W  combinational read data for rd_addr (same cycle)
//   wr_en    1       one-cycle write strobe
//   wr_addr  16      write address
//   wr_data  DATA_W  write data
// Modports: master (sequencer side), slave (bank side).

interface inst_sequencer_if #(
  parameter int DATA_W = 64
);

  logic [15:0]       rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [15:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational ALU for inst_sequencer
//
// Purpose: computes the write-back value for one instruction.
// Ports:
//   opcode  in   4       instruction opcode
//   a       in   DATA_W  operand A (srcA register)
//   b       in   DATA_W  operand B (srcB register)
//   result  out  DATA_W  ALU result, modulo 2^DATA_W

module seq_alu
  import inst_seq_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  // Carry and borrow fall off the top; results wrap modulo 2^DATA_W.
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_SHL1: result = {a[DATA_W-2:0], 1'b0};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - instruction sequencer driving the 64-bit register bank
//
// Purpose: on op_start, fetches I0..I(NUM_INST-1), reads operands from R0..R9,
//          executes one ALU op per instruction, writes results back, then writes
//          a status word to INTERRUPT and raises the interrupt unless masked.
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   op_start   in   1   OP_START[0]; starts a run from IDLE
//   int_mask   in   1   INT_MASK[0]; 1 suppresses interrupt
//   bank       master   register bank bus (rd_addr/rd_data/wr_en/wr_addr/wr_data)
//   busy       out  1   high from FETCH through FINISH
//   interrupt  out  1   registered completion interrupt

module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int NUM_INST = 10,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_start,
  input  logic                int_mask,
  inst_sequencer_if.master    bank,
  output logic                busy,
  output logic                interrupt
);

  localparam int PC_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_INST - 1);

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc, pc_nx;
  logic [3:0]        op_q, op_nx;
  logic [3:0]        dst_q, dst_nx;
  logic [3:0]        srca_q, srca_nx;
  logic [3:0]        srcb_q, srcb_nx;
  logic [DATA_W-1:0] opa_q, opa_nx;
  logic [DATA_W-1:0] opb_q, opb_nx;
  logic [1:0]        status_q, status_nx;
  logic              interrupt_nx;
  logic [DATA_W-1:0] alu_result;

  // Fields of the fetched word taken straight from the read mux so FETCH can
  // decide its successor in the same cycle it latches them.
  logic [3:0] f_op, f_dst, f_srca, f_srcb;
  assign f_op   = bank.rd_data[DATA_W-1:DATA_W-4];
  assign f_dst  = bank.rd_data[11:8];
  assign f_srcb = bank.rd_data[7:4];
  assign f_srca = bank.rd_data[3:0];

  // Bits outside the decoded fields are don't-care.
  logic unused_inst_bits;
  assign unused_inst_bits = ^bank.rd_data[DATA_W-5:12];

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      status_q  <= '0;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      op_q      <= op_nx;
      dst_q     <= dst_nx;
      srca_q    <= srca_nx;
      srcb_q    <= srcb_nx;
      opa_q     <= opa_nx;
      opb_q     <= opb_nx;
      status_q  <= status_nx;
      interrupt <= interrupt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    op_nx        = op_q;
    dst_nx       = dst_q;
    srca_nx      = srca_q;
    srcb_nx      = srcb_q;
    opa_nx       = opa_q;
    opb_nx       = opb_q;
    status_nx    = status_q;
    interrupt_nx = 1'b0;
    busy         = 1'b0;
    bank.rd_addr = '0;
    bank.wr_en   = 1'b0;
    bank.wr_addr = '0;
    bank.wr_data = '0;

    case (state)
      S_IDLE: begin
        if (op_start) begin
          pc_nx    = '0;
          state_nx = S_FETCH;
        end
      end

      S_FETCH: begin
        busy         = 1'b1;
        bank.rd_addr = INST_BASE + 16'(pc);
        op_nx        = f_op;
        dst_nx       = f_dst;
        srca_nx      = f_srca;
        srcb_nx      = f_srcb;
        if (f_op == OP_HALT) begin
          status_nx = ST_OK;
          state_nx  = S_FINISH;
        end else if (f_op == OP_NOP) begin
          state_nx = S_NEXT;
        end else if (!is_alu_op(f_op)) begin
          status_nx = ST_ERR;
          state_nx  = S_FINISH;
        end else if (!reg_ok(f_srca) || !reg_ok(f_srcb) || !reg_ok(f_dst)) begin
          status_nx = ST_ERR;
          state_nx  = S_FINISH;
        end else begin
          state_nx = S_READ_A;
        end
      end

      S_READ_A: begin
        busy         = 1'b1;
        bank.rd_addr = DATA_BASE + 16'(srca_q);
        opa_nx       = bank.rd_data;
        state_nx     = S_READ_B;
      end

      S_READ_B: begin
        busy         = 1'b1;
        bank.rd_addr = DATA_BASE + 16'(srcb_q);
        opb_nx       = bank.rd_data;
        state_nx     = S_WRITE;
      end

      // Both operands are already latched, so dst may alias srcA/srcB.
      S_WRITE: begin
        busy         = 1'b1;
        bank.wr_en   = 1'b1;
        bank.wr_addr = DATA_BASE + 16'(dst_q);
        bank.wr_data = alu_result;
        state_nx     = S_NEXT;
      end

      S_NEXT: begin
        busy = 1'b1;
        if (pc == PC_LAST) begin
          status_nx = ST_OK;
          state_nx  = S_FINISH;
        end else begin
          pc_nx    = pc + PC_W'(1);
          state_nx = S_FETCH;
        end
      end

      // Interrupt is loaded on the way into DONE so it is valid in DONE's
      // first cycle.
      S_FINISH: begin
        busy         = 1'b1;
        bank.wr_en   = 1'b1;
        bank.wr_addr = INTR_ADDR;
        bank.wr_data = {{(DATA_W-2){1'b0}}, status_q};
        interrupt_nx = ~int_mask;
        state_nx     = S_DONE;
      end

      // Holding op_start parks here; mask is re-sampled every cycle.
      S_DONE: begin
        if (op_start) begin
          interrupt_nx = ~int_mask;
        end else begin
          state_nx = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - self-checking bench for inst_sequencer

module tb_inst_sequencer;
  import inst_seq_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_start = 1'b0;
  logic int_mask = 1'b0;
  logic busy;
  logic interrupt;

  logic [63:0] mem [0:511];
  wr_t         exp_q [$];
  logic [15:0] fetch_log [$];
  wr_t         mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  inst_sequencer_if #(.DATA_W(64)) bus ();
  assign bus.rd_data = mem[bus.rd_addr[8:0]];

  inst_sequencer #(.NUM_INST(10), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_start  (op_start),
    .int_mask  (int_mask),
    .bank      (bus),
    .busy      (busy),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bank model: compare each write strobe with the scoreboard, then commit it.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_addr >= 16'h0110 && bus.rd_addr <= 16'h0119)
        fetch_log.push_back(bus.rd_addr);
      if (bus.wr_en === 1'b1) begin
        check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
          check("wr_data", bus.wr_data, mon_e.data);
        end
        mem[bus.wr_addr[8:0]] = bus.wr_data;
      end
    end
  end

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [3:0] dst,
                                     input logic [3:0] srcb, input logic [3:0] srca);
    return {op, 48'h0, dst, srcb, srca};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 64'h0;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [63:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Starts a run and returns the number of busy cycles; drop_at>0 releases
  // op_start after that many busy cycles.
  task automatic run(input int drop_at, output int cycles);
    bit done;
    done = 1'b0;
    cycles = 0;
    op_start = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      step();
      if (busy) begin
        cycles++;
        if (cycles == drop_at) op_start = 1'b0;
      end else if (cycles > 0) begin
        done = 1'b1;
      end
    end
    check("run_completes", 64'(done), 64'd1);
  endtask

  task automatic finish_run();
    op_start = 1'b0;
    step();
    step();
    check("idle_interrupt", 64'(interrupt), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    clear_mem();
    repeat (3) step();
    check("rst_interrupt", 64'(interrupt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_wr_data", bus.wr_data, 64'd0);
    reset = 1'b0;
    step();

    // ADD then HALT, interrupt unmasked, op_start held in DONE
    mem[9'h101] = 64'd5;
    mem[9'h102] = 64'd3;
    mem[9'h110] = mk(OP_ADD, 4'd3, 4'd2, 4'd1);
    mem[9'h111] = mk(OP_HALT, 4'd0, 4'd0, 4'd0);
    expect_wr(16'h0103, 64'd8);
    expect_wr(16'h0122, 64'd1);
    run(0, cyc);
    check("add_cycles", 64'(cyc), 64'd7);
    check("add_interrupt", 64'(interrupt), 64'd1);
    check("add_busy", 64'(busy), 64'd0);
    step();
    check("hold_done_busy", 64'(busy), 64'd0);
    check("hold_done_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("hold_done_interrupt", 64'(interrupt), 64'd1);
    finish_run();

    // All NOP: ten fetches, status write only
    clear_mem();
    fetch_log.delete();
    expect_wr(16'h0122, 64'd1);
    run(0, cyc);
    check("nop_cycles", 64'(cyc), 64'd21);
    check("nop_fetch_count", 64'(fetch_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < fetch_log.size(); i++)
      check("nop_fetch_addr", 64'(fetch_log[i]), 64'(16'h0110 + i));
    finish_run();

    // SUB wraps, SHL1 with dst aliasing srcA; op_start dropped mid-run
    clear_mem();
    mem[9'h101] = 64'd1;
    mem[9'h104] = 64'd0;
    mem[9'h110] = mk(OP_SUB, 4'd4, 4'd1, 4'd4);
    mem[9'h111] = mk(OP_SHL1, 4'd4, 4'd0, 4'd4);
    mem[9'h112] = mk(OP_HALT, 4'd0, 4'd0, 4'd0);
    expect_wr(16'h0104, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_wr(16'h0104, 64'hFFFF_FFFF_FFFF_FFFE);
    expect_wr(16'h0122, 64'd1);
    run(2, cyc);
    check("sub_shl_cycles", 64'(cyc), 64'd12);
    check("sub_shl_interrupt", 64'(interrupt), 64'd1);
    finish_run();

    // Illegal opcode 9
    clear_mem();
    mem[9'h110] = {4'h9, 60'h0};
    expect_wr(16'h0122, 64'd2);
    run(0, cyc);
    check("illegal_cycles", 64'(cyc), 64'd2);
    check("illegal_interrupt", 64'(interrupt), 64'd1);
    finish_run();

    // ADD with out-of-range dst
    clear_mem();
    mem[9'h110] = mk(OP_ADD, 4'hC, 4'd2, 4'd1);
    expect_wr(16'h0122, 64'd2);
    run(0, cyc);
    check("baddst_cycles", 64'(cyc), 64'd2);
    check("baddst_interrupt", 64'(interrupt), 64'd1);
    finish_run();

    // Masked completion, then unmask while in DONE
    clear_mem();
    mem[9'h110] = mk(OP_HALT, 4'd0, 4'd0, 4'd0);
    int_mask = 1'b1;
    expect_wr(16'h0122, 64'd1);
    run(0, cyc);
    check("mask_cycles", 64'(cyc), 64'd2);
    check("mask_interrupt_0", 64'(interrupt), 64'd0);
    step();
    check("mask_interrupt_1", 64'(interrupt), 64'd0);
    int_mask = 1'b0;
    step();
    check("unmask_interrupt", 64'(interrupt), 64'd1);
    finish_run();

    // Reset during READ_B, then restart from pc=0
    clear_mem();
    mem[9'h101] = 64'd5;
    mem[9'h102] = 64'd3;
    mem[9'h105] = 64'h77;
    mem[9'h110] = mk(OP_ADD, 4'd5, 4'd2, 4'd1);
    mem[9'h111] = mk(OP_HALT, 4'd0, 4'd0, 4'd0);
    op_start = 1'b1;
    step();
    step();
    step();
    check("rb_busy", 64'(busy), 64'd1);
    check("rb_rd_addr", 64'(bus.rd_addr), 64'h0102);
    reset = 1'b1;
    op_start = 1'b0;
    step();
    check("rstmid_wr_en", 64'(bus.wr_en), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("rstmid_interrupt", 64'(interrupt), 64'd0);
    reset = 1'b0;
    step();
    check("rstmid_dst_untouched", mem[9'h105], 64'h77);
    fetch_log.delete();
    expect_wr(16'h0105, 64'd8);
    expect_wr(16'h0122, 64'd1);
    run(0, cyc);
    check("restart_cycles", 64'(cyc), 64'd7);
    check("restart_first_fetch", 64'(fetch_log.size() != 0 ? fetch_log[0] : 16'hFFFF), 64'h0110);
    finish_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
